// File: rtl/legv8_prog_encoder.sv
// LEGv8 program-image encoder: turns decoded LDUR/STUR/CBZ/ADD/SUB/AND/ORR fields into
// machine words and streams them with sequential word addresses to an instruction-memory port.
module legv8_prog_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic              in_last,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rn,
  input  logic [4:0]        in_rm,
  input  logic [18:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0]      OP_ILLEGAL = 3'd7;
  localparam logic [ADDR_W:0] LAST_ADDR  = {1'b0, {ADDR_W{1'b1}}};
  localparam logic [ADDR_W:0] ONE        = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_word_q, out_word_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              err_q, err_d;

  logic accept, legal, emit, drain;

  function automatic logic [31:0] encode(input logic [2:0] op, input logic [4:0] rd,
                                         input logic [4:0] rn, input logic [4:0] rm,
                                         input logic [18:0] imm);
    logic [31:0] w;
    w = '0;
    case (op)
      3'd0:    w = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
      3'd1:    w = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
      3'd2:    w = {8'b10110100, imm, rd};
      3'd3:    w = {11'b10001011000, rm, 6'b000000, rn, rd};
      3'd4:    w = {11'b11001011000, rm, 6'b000000, rn, rd};
      3'd5:    w = {11'b10001010000, rm, 6'b000000, rn, rd};
      3'd6:    w = {11'b10101010000, rm, 6'b000000, rn, rd};
      default: w = '0;
    endcase
    return w;
  endfunction

  // The address counter is one bit wider than out_addr so a full image shows up as its MSB.
  always_comb begin
    in_ready = (state_q == S_LOAD) && (!out_valid_q || out_ready) && !addr_q[ADDR_W];
    accept   = in_valid && in_ready;
    legal    = (in_op != OP_ILLEGAL);
    emit     = accept && legal;
    drain    = out_valid_q && out_ready;

    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    out_word_d  = out_word_q;
    out_addr_d  = out_addr_q;
    err_d       = err_q;

    if (drain) begin
      out_valid_d = 1'b0;
      count_d     = count_q + ONE;
    end
    if (emit) begin
      out_valid_d = 1'b1;
      out_word_d  = encode(in_op, in_rd, in_rn, in_rm, in_imm);
      out_addr_d  = addr_q[ADDR_W-1:0];
      addr_d      = addr_q + ONE;
    end
    if (accept && !legal) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          addr_d  = '0;
          count_d = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (accept && (in_last || (legal && addr_q == LAST_ADDR))) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
      out_addr_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_word_q  <= out_word_d;
      out_addr_q  <= out_addr_d;
      err_q       <= err_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_word   = out_word_q;
  assign out_addr   = out_addr_q;
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign word_count = count_q;

endmodule

// File: tb/tb_legv8_prog_encoder.sv
// Scoreboard bench for legv8_prog_encoder with a small (4-word) image so the full-image path is
// exercised; expected words come from an arithmetic encoding model kept here.
module tb_legv8_prog_encoder;

  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          resetN;
  logic          start;
  logic          inValid;
  logic          inReady;
  logic [2:0]    inOp;
  logic          inLast;
  logic [4:0]    inRd, inRn, inRm;
  logic [18:0]   inImm;
  logic          outValid;
  logic          outReady;
  logic [31:0]   outWord;
  logic [AW-1:0] outAddr;
  logic          busy, done, err;
  logic [AW:0]   wordCount;

  legv8_prog_encoder #(.ADDR_W(AW)) dut (
    .clk(clk), .reset(resetN), .start(start),
    .in_valid(inValid), .in_ready(inReady), .in_op(inOp), .in_last(inLast),
    .in_rd(inRd), .in_rn(inRn), .in_rm(inRm), .in_imm(inImm),
    .out_valid(outValid), .out_ready(outReady), .out_word(outWord), .out_addr(outAddr),
    .busy(busy), .done(done), .err(err), .word_count(wordCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] w;
    int          a;
  } exp_t;

  exp_t expQ[$];
  int   mState;
  int   mAddr;
  int   mCount;
  bit   mErr;
  int   nVectors = 0;
  int   nMiss    = 0;
  bit   randReady = 0;

  // Opcode field [31:21] per op, as listed in the instruction set tables.
  int opcTab[7] = '{'h7C2, 'h7C0, 0, 'h458, 'h658, 'h450, 'h550};

  function automatic logic [31:0] refEncode(int op, int rd, int rn, int rm, int imm);
    longint v;
    if (op == 2)
      v = (longint'('hB4) << 24) + longint'(imm) * 32 + rd;
    else if (op <= 1)
      v = (longint'(opcTab[op]) << 21) + longint'(imm % 512) * 4096 + rn * 32 + rd;
    else
      v = (longint'(opcTab[op]) << 21) + longint'(rm) * 65536 + rn * 32 + rd;
    return v[31:0];
  endfunction

  function automatic bit modelReady();
    return (mState == 1) && (expQ.size() == 0 || outReady) && (mAddr < DEPTH);
  endfunction

  task automatic checkOutput(string name, longint act, longint exp);
    nVectors++;
    if (act != exp) begin
      nMiss++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances on each rising edge from the inputs the bench is driving.
  always @(posedge clk) begin : model
    bit rdy, hs;
    if (!resetN) begin
      expQ.delete();
      mState = 0; mAddr = 0; mCount = 0; mErr = 0;
    end else begin
      rdy = modelReady();
      hs  = (expQ.size() > 0) && outReady;
      if (hs) begin
        void'(expQ.pop_front());
        mCount++;
      end
      if (mState != 1 && start) begin
        mState = 1; mAddr = 0; mCount = 0; mErr = 0;
      end else if (inValid && rdy) begin
        if (inOp == 3'd7) begin
          mErr = 1;
        end else begin
          expQ.push_back('{w: refEncode(int'(inOp), int'(inRd), int'(inRn), int'(inRm), int'(inImm)),
                           a: mAddr});
          if (mAddr == DEPTH - 1) mState = 2;
          mAddr++;
        end
        if (inLast) mState = 2;
      end
    end
  end

  // Monitor: compares the presented word and status against the model, away from the clock edge.
  always @(negedge clk) begin
    if (resetN) begin
      checkOutput("out_valid", outValid, expQ.size() > 0);
      checkOutput("in_ready", inReady, modelReady());
      checkOutput("busy", busy, mState == 1);
      checkOutput("done", done, mState == 2);
      checkOutput("err", err, mErr);
      checkOutput("word_count", wordCount, mCount);
      if (outValid && expQ.size() > 0) begin
        checkOutput("out_word", outWord, expQ[0].w);
        checkOutput("out_addr", outAddr, expQ[0].a);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (randReady) outReady = 1'($urandom_range(0, 1));
    end
  end

  task automatic idleCycles(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic startPulse();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic applyStimulus(int op, int rd, int rn, int rm, int imm, bit last);
    bit accepted;
    accepted = 0;
    inOp  = 3'(op);  inRd = 5'(rd); inRn = 5'(rn); inRm = 5'(rm);
    inImm = 19'(imm); inLast = last; inValid = 1'b1;
    for (int t = 0; t < 100 && !accepted; t++) begin
      @(negedge clk);
      if (inReady) begin
        @(posedge clk);
        #1;
        accepted = 1;
      end
    end
    if (!accepted) begin
      nVectors++;
      nMiss++;
      $display("[TB] FAIL accept_timeout: op %0d not accepted, expected acceptance", op);
      @(posedge clk);
      #1;
    end
    inValid = 1'b0;
    inLast  = 1'b0;
  endtask

  initial begin
    int n, op;
    resetN = 1'b0; start = 1'b0; inValid = 1'b1; inLast = 1'b0; outReady = 1'b1;
    inOp = 3'd3; inRd = 5'd1; inRn = 5'd2; inRm = 5'd3; inImm = 19'h12345;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", inReady, 0);
    checkOutput("rst_out_valid", outValid, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_out_word", outWord, 0);
    checkOutput("rst_word_count", wordCount, 0);
    @(posedge clk);
    #1;
    resetN = 1'b1; inValid = 1'b0;
    idleCycles(1);

    $display("[TB] first ADD");
    startPulse();
    @(negedge clk);
    checkOutput("start_busy", busy, 1);
    @(posedge clk);
    #1;
    applyStimulus(3, 3, 1, 2, 0, 1);
    @(negedge clk);
    checkOutput("add_word", outWord, 32'h8B020023);
    checkOutput("add_addr", outAddr, 0);
    idleCycles(2);

    $display("[TB] LDUR/STUR back-to-back");
    startPulse();
    applyStimulus(0, 2, 0, 0, 8, 0);
    applyStimulus(1, 1, 2, 0, 0, 0);
    @(negedge clk);
    checkOutput("stur_word", outWord, 32'hF8000041);
    checkOutput("stur_addr", outAddr, 1);
    idleCycles(2);
    checkOutput("ldst_count", wordCount, 2);

    $display("[TB] CBZ with stalled memory");
    outReady = 1'b0;
    applyStimulus(2, 5, 0, 0, 3, 1);
    repeat (4) begin
      @(negedge clk);
      checkOutput("cbz_hold_word", outWord, 32'hB4000065);
      checkOutput("cbz_hold_ready", inReady, 0);
      checkOutput("cbz_hold_done", done, 1);
    end
    @(posedge clk);
    #1;
    outReady = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("cbz_drained", outValid, 0);
    checkOutput("cbz_count", wordCount, 3);
    idleCycles(1);

    $display("[TB] illegal op between ADDs");
    startPulse();
    applyStimulus(3, 4, 5, 6, 0, 0);
    applyStimulus(7, 1, 1, 1, 0, 0);
    applyStimulus(3, 7, 8, 9, 0, 1);
    idleCycles(3);
    checkOutput("illegal_err", err, 1);
    checkOutput("illegal_count", wordCount, 2);

    $display("[TB] fill the image");
    startPulse();
    @(negedge clk);
    checkOutput("restart_err", err, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++) applyStimulus(3, i, i + 1, i + 2, 0, 0);
    inValid = 1'b1; inOp = 3'd3;
    repeat (3) begin
      @(negedge clk);
      checkOutput("full_in_ready", inReady, 0);
      checkOutput("full_done", done, 1);
    end
    @(posedge clk);
    #1;
    inValid = 1'b0;
    idleCycles(2);
    checkOutput("full_count", wordCount, DEPTH);
    startPulse();
    applyStimulus(4, 9, 10, 11, 0, 1);
    idleCycles(2);

    $display("[TB] randomized images");
    randReady = 1;
    for (int img = 0; img < 40; img++) begin
      startPulse();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        if (mState != 1) break;
        op = ($urandom_range(0, 9) == 0) ? 7 : $urandom_range(0, 6);
        applyStimulus(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                      $urandom_range(0, 19'h7FFFF), i == n - 1);
      end
    end
    randReady = 0;
    outReady  = 1'b1;
    idleCycles(3);
    checkOutput("final_drain", expQ.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiss);
    $finish;
  end

endmodule

// File: doc/legv8_prog_encoder.md
Name: legv8_prog_encoder

Overview:
- Encodes the LEGv8 subset LDUR, STUR, CBZ, ADD, SUB, AND, ORR from decoded fields into 32-bit machine words.
- Streams the words, with sequential word addresses, to the instruction-memory write port. This is the encoder/writer counterpart of the main decoder.
- Used by benches and by the boot loader to build a program image at run time.
- One result register with valid/ready on both sides. A program-load FSM tracks the address and fill state.

Parameters:
ADDR_W, 6, width of the word address; image depth is 2**ADDR_W words.

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-low reset
start  in  1  pulse; begin a new image at address 0
in_valid  in  1  instruction fields valid
in_ready  out  1  encoder can accept fields this cycle
in_op  in  3  0=LDUR 1=STUR 2=CBZ 3=ADD 4=SUB 5=AND 6=ORR 7=illegal
in_last  in  1  marks the final instruction of the image
in_rd  in  5  Rd (R-type) / Rt (D-type, CB-type)
in_rn  in  5  Rn
in_rm  in  5  Rm
in_imm  in  19  D-type uses [8:0] (DT_address); CB-type uses [18:0] (BR address)
out_valid  out  1  out_word/out_addr valid
out_ready  in  1  memory accepts the word
out_word  out  32  encoded instruction
out_addr  out  ADDR_W  word address
busy  out  1  FSM in LOAD
done  out  1  image complete (last or full)
err  out  1  sticky; an illegal op was received
word_count  out  ADDR_W+1  words emitted since start

Behaviour:
- Reset (reset==0 at a clock edge): FSM=IDLE; outputs in_ready, out_valid, busy, done and err =0; out_word, out_addr and word_count =0. Reset mid-transfer discards any pending word.
- FSM states: IDLE, LOAD, DONE.
  - IDLE: start moves to LOAD and clears address, word_count, err and done.
  - LOAD: fields are accepted.
  - DONE: done=1; only start leaves (to LOAD, same clears as from IDLE).
  - start is ignored while in LOAD.
- in_ready = (state==LOAD) && (!out_valid || out_ready) && (address < 2**ADDR_W).
- Accept = in_valid && in_ready. On accept, the encoded word is registered: out_valid=1 on the next cycle (latency 1).
- A new accept may occur in the same cycle the held word drains, giving full throughput of 1 word/cycle.
- out_word, out_addr and out_valid hold stable while out_valid && !out_ready.
- Encoding, bit fields:
  - R-type ADD/SUB/AND/ORR: [31:21]=10001011000 / 11001011000 / 10001010000 / 10101010000; [20:16]=Rm; [15:10]=0; [9:5]=Rn; [4:0]=Rd.
  - D-type LDUR/STUR: [31:21]=11111000010 / 11111000000; [20:12]=imm[8:0]; [11:10]=00; [9:5]=Rn; [4:0]=Rt.
  - CB-type CBZ: [31:24]=10110100; [23:5]=imm[18:0]; [4:0]=Rt.
  - Unused input fields are ignored.
- Illegal op (7) on accept: no word is produced and the address is not advanced; err is set sticky. in_last still moves to DONE.
- Address: out_addr takes the current address counter on each emitted word; the counter increments by 1 on each accepted legal op. word_count increments when a word handshakes (out_valid && out_ready).
- Completion:
  - Accept with in_last=1, or accept of the word at address 2**ADDR_W-1, moves to DONE.
  - The final word is still presented and must drain: out_valid stays valid in DONE until out_ready.
  - There is no wrap-around. Once the image is full, in_ready=0.
- start coincident with reset: reset wins.

Test Plan:
- Reset held low 3 cycles with in_valid=1 -> in_ready=0, out_valid=0, err=0, out_word=0x00000000; release, pulse start -> busy=1.
- ADD X3,X1,X2 (op=3, rd=3, rn=1, rm=2) with out_ready=1 -> next cycle out_word=0x8B020023, out_addr=0.
- LDUR X2,[X0,#8] then STUR X1,[X2,#0] back-to-back -> out_word 0xF8408002 @0, then 0xF8000041 @1; in_ready stays 1 and word_count=2.
- CBZ X5,imm=3 with in_last=1 and out_ready held 0 for 4 cycles -> out_word=0xB4000065 is held stable, in_ready=0, done=1; after out_ready=1, out_valid drops and word_count increments.
- op=7 between two ADDs -> err=1 sticky; the two ADD words land at addresses 0 and 1 with no gap.
- ADDR_W=2, stream 5 ADDs -> 4 words at addresses 0..3, then done=1 and in_ready=0; a new start restarts at address 0 with err cleared.
